// File: rtl/simple_bus_pkg.sv
// Shared definitions for the simple bus slave memory: FSM states, mode bit
// encoding, wait-state limit and a saturating counter helper.
package simple_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } bus_state_e;

   localparam logic MODE_READ  = 1'b0;
   localparam logic MODE_WRITE = 1'b1;

   localparam int WAIT_CYCLES_MAX = 15;

   // 16-bit increment that sticks at all-ones
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bus_slave_mem_if.sv
// Bus bundle between a master and the slave memory. The master drives the
// request/command side; the slave returns grant, completion and read data.
interface bus_slave_mem_if #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 8
) ();

   logic              req;
   logic              gnt;
   logic              start;
   logic [1:0]        mode;
   logic [AWIDTH-1:0] addr;
   logic [DWIDTH-1:0] wdata;
   logic [DWIDTH-1:0] rdata;
   logic              rdata_oe;
   logic              rdy;

   modport master (
      output req, start, mode, addr, wdata,
      input  gnt, rdata, rdata_oe, rdy
   );

   modport slave (
      input  req, start, mode, addr, wdata,
      output gnt, rdata, rdata_oe, rdy
   );

endinterface

// File: rtl/bus_slave_mem_array.sv
// Single-port synchronous RAM. The read register only updates on a read
// access, so it keeps the last read word between transfers. No reset.
module bus_slave_mem_array #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [AWIDTH-1:0] addr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   output logic [DWIDTH-1:0] rdata_o
);

   logic [DWIDTH-1:0] mem_q [2**AWIDTH];
   logic [DWIDTH-1:0] rdata_q;

   // One access per enabled cycle: write the array or register a read
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) mem_q[addr_i] <= wdata_i;
         else      rdata_q       <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_slave_mem.sv
// Bus slave memory: request/grant handshake, start strobe, WAIT_CYCLES wait
// states, then a one-cycle DONE with rdy. Optional transfer counters are
// enabled with the macro BUS_SLAVE_MEM_STATS_EN.
module bus_slave_mem #(
   parameter int AWIDTH      = 8,
   parameter int DWIDTH      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
`ifdef BUS_SLAVE_MEM_STATS_EN
   output logic [15:0]        rd_count,
   output logic [15:0]        wr_count,
`endif
   bus_slave_mem_if.slave     bus
);

   import simple_bus_pkg::*;

   localparam int         WAIT_EFF  = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
   localparam logic [3:0] WAIT_LD   = 4'(WAIT_EFF);
   localparam bit         ZERO_WAIT = (WAIT_EFF == 0);

   bus_state_e        state_q;
   logic              gnt_q;
   logic              rdy_q;
   logic              oe_q;
   logic              rd_seen_q;
   logic [3:0]        cnt_q;
   logic [AWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] wdata_q;
   logic              wr_q;

   logic              start_wr;
   logic              ram_en_d;
   logic              ram_we_d;
   logic [AWIDTH-1:0] ram_addr_d;
   logic [DWIDTH-1:0] ram_wdata_d;
   logic [DWIDTH-1:0] ram_rdata;

   assign start_wr = (bus.mode[0] == MODE_WRITE);

   // RAM command: with zero wait states the access happens on the start edge
   // itself, so the live bus command is used while in GRANT
   always_comb begin
      ram_en_d    = 1'b0;
      ram_we_d    = wr_q;
      ram_addr_d  = addr_q;
      ram_wdata_d = wdata_q;
      if (state_q == GRANT) begin
         ram_we_d    = start_wr;
         ram_addr_d  = bus.addr;
         ram_wdata_d = bus.wdata;
      end
      if (!rst) begin
         if (ZERO_WAIT && state_q == GRANT && bus.start) ram_en_d = 1'b1;
         if (state_q == ACCESS && cnt_q == 4'd1)         ram_en_d = 1'b1;
      end
   end

   // Capture the command on an accepted start; datapath needs no reset
   always_ff @(posedge clk) begin
      if (state_q == GRANT && bus.start) begin
         addr_q  <= bus.addr;
         wdata_q <= bus.wdata;
         wr_q    <= start_wr;
      end
   end

   // Bus FSM with registered grant/ready/output-enable
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         rdy_q     <= 1'b0;
         oe_q      <= 1'b0;
         cnt_q     <= 4'd0;
         rd_seen_q <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         oe_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req) begin
                  state_q <= GRANT;
                  gnt_q   <= 1'b1;
               end
            end
            GRANT: begin
               if (bus.start) begin
                  if (ZERO_WAIT) begin
                     state_q <= DONE;
                     rdy_q   <= 1'b1;
                     oe_q    <= !start_wr;
                  end else begin
                     state_q <= ACCESS;
                     cnt_q   <= WAIT_LD;
                  end
               end else if (!bus.req) begin
                  state_q <= IDLE;
                  gnt_q   <= 1'b0;
               end
            end
            ACCESS: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= DONE;
                  rdy_q   <= 1'b1;
                  oe_q    <= !wr_q;
               end
            end
            DONE: begin
               if (bus.req) begin
                  state_q <= GRANT;
               end else begin
                  state_q <= IDLE;
                  gnt_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= 1'b0;
            end
         endcase
         if (ram_en_d && !ram_we_d) rd_seen_q <= 1'b1;
      end
   end

   bus_slave_mem_array #(
      .AWIDTH (AWIDTH),
      .DWIDTH (DWIDTH)
   ) u_array (
      .clk     (clk),
      .en_i    (ram_en_d),
      .we_i    (ram_we_d),
      .addr_i  (ram_addr_d),
      .wdata_i (ram_wdata_d),
      .rdata_o (ram_rdata)
   );

   assign bus.gnt      = gnt_q;
   assign bus.rdy      = rdy_q;
   assign bus.rdata_oe = oe_q;
   // Reads zero until the first read after reset, then holds the last read
   assign bus.rdata    = rd_seen_q ? ram_rdata : '0;

`ifdef BUS_SLAVE_MEM_STATS_EN
   logic [15:0] rd_count_q;
   logic [15:0] wr_count_q;

   // Count completed transfers in DONE, saturating at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_count_q <= 16'd0;
         wr_count_q <= 16'd0;
      end else if (state_q == DONE) begin
         if (wr_q) wr_count_q <= sat_inc16(wr_count_q);
         else      rd_count_q <= sat_inc16(rd_count_q);
      end
   end

   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_bus_slave_mem.sv
// Self-checking bench for bus_slave_mem: one instance with two wait states,
// one with zero wait states; a select bit routes the stimulus to one of them.
module tb_bus_slave_mem;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit         sel     = 1'b0;
   logic       req_t   = 1'b0;
   logic       start_t = 1'b0;
   logic [1:0] mode_t  = 2'b00;
   logic [7:0] addr_t  = 8'h00;
   logic [7:0] wdata_t = 8'h00;

   bus_slave_mem_if #(.AWIDTH(8), .DWIDTH(8)) b2 ();
   bus_slave_mem_if #(.AWIDTH(8), .DWIDTH(8)) b0 ();

   assign b2.req   = req_t & ~sel;
   assign b2.start = start_t & ~sel;
   assign b2.mode  = mode_t;
   assign b2.addr  = addr_t;
   assign b2.wdata = wdata_t;
   assign b0.req   = req_t & sel;
   assign b0.start = start_t & sel;
   assign b0.mode  = mode_t;
   assign b0.addr  = addr_t;
   assign b0.wdata = wdata_t;

`ifdef BUS_SLAVE_MEM_STATS_EN
   logic [15:0] rd_cnt2, wr_cnt2, rd_cnt0, wr_cnt0;
`endif

   bus_slave_mem #(.AWIDTH(8), .DWIDTH(8), .WAIT_CYCLES(2)) u_dut2 (
      .clk      (clk),
      .rst      (rst),
`ifdef BUS_SLAVE_MEM_STATS_EN
      .rd_count (rd_cnt2),
      .wr_count (wr_cnt2),
`endif
      .bus      (b2)
   );

   bus_slave_mem #(.AWIDTH(8), .DWIDTH(8), .WAIT_CYCLES(0)) u_dut0 (
      .clk      (clk),
      .rst      (rst),
`ifdef BUS_SLAVE_MEM_STATS_EN
      .rd_count (rd_cnt0),
      .wr_count (wr_cnt0),
`endif
      .bus      (b0)
   );

   wire       gnt_v   = sel ? b0.gnt      : b2.gnt;
   wire       rdy_v   = sel ? b0.rdy      : b2.rdy;
   wire       oe_v    = sel ? b0.rdata_oe : b2.rdata_oe;
   wire [7:0] rdata_v = sel ? b0.rdata    : b2.rdata;

   int rdy_cnt = 0;
   always @(negedge clk) if (b2.rdy || b0.rdy) rdy_cnt <= rdy_cnt + 1;

   typedef struct {
      bit         rd;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       sbq[$];
   logic [7:0] mem_m [256];
   int         n_cmp  = 0;
   int         n_fail = 0;

   // Drive one start at the current negedge, record the expected outcome
   task automatic drive_start(input bit wr, input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      int   w;
      w         = sel ? 0 : 2;
      addr_t    = a;
      wdata_t   = d;
      mode_t[1] = 1'($urandom_range(0, 1));
      mode_t[0] = wr;
      start_t   = 1'b1;
      e.rd      = !wr;
      e.data    = wr ? d : mem_m[a];
      e.cyc     = cyc + w + 1;
      sbq.push_back(e);
      if (wr) mem_m[a] = d;
      @(negedge clk);
      start_t = 1'b0;
      addr_t  = 8'($urandom);
      wdata_t = 8'($urandom);
      mode_t  = 2'($urandom);
   endtask

   task automatic wait_rdy(output int c, output bit to);
      to = 1'b1;
      c  = -1;
      for (int i = 0; i < 40; i++) begin
         if (rdy_v) begin
            to = 1'b0;
            c  = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                       output int c, output bit to, output logic oe, output logic [7:0] rd);
      drive_start(wr, a, d);
      wait_rdy(c, to);
      oe = oe_v;
      rd = rdata_v;
   endtask

   task automatic get_grant();
      req_t = 1'b1;
      for (int i = 0; i < 10 && !gnt_v; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({b2.gnt, b2.rdy, b2.rdata_oe, b2.rdata} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_w2: gnt/rdy/oe/rdata=%b, expected all 0", {b2.gnt, b2.rdy, b2.rdata_oe, b2.rdata});
      end
      n_cmp++;
      if ({b0.gnt, b0.rdy, b0.rdata_oe, b0.rdata} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_w0: gnt/rdy/oe/rdata=%b, expected all 0", {b0.gnt, b0.rdy, b0.rdata_oe, b0.rdata});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_req_no_start();
      int r0;
      bit ex;
      sel = 1'b0;
      @(negedge clk);
      r0    = rdy_cnt;
      req_t = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) req_t = 1'b0;
         ex = (i >= 1 && i <= 3);
         n_cmp++;
         if (gnt_v !== ex) begin
            n_fail++;
            $display("FAIL req_gnt[%0d]: gnt=%b, expected %b", i, gnt_v, ex);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (rdy_cnt != r0) begin
         n_fail++;
         $display("FAIL req_no_rdy: rdy pulses=%0d, expected 0", rdy_cnt - r0);
      end
   endtask

   task automatic test_write_read();
      int c; bit to; logic oe; logic [7:0] rd; exp_t e;
      sel = 1'b0;
      get_grant();
      xfer(1'b1, 8'h10, 8'hA5, c, to, oe, rd);
      e = sbq.pop_front();
      n_cmp++;
      if (to || c != e.cyc) begin n_fail++; $display("FAIL wr_latency: rdy cycle %0d, expected %0d", c, e.cyc); end
      n_cmp++;
      if (oe !== 1'b0) begin n_fail++; $display("FAIL wr_oe: oe=%b, expected 0", oe); end
      @(negedge clk);
      n_cmp++;
      if (rdy_v !== 1'b0) begin n_fail++; $display("FAIL rdy_pulse: rdy=%b one cycle after DONE, expected 0", rdy_v); end
      xfer(1'b0, 8'h10, 8'h00, c, to, oe, rd);
      e = sbq.pop_front();
      n_cmp++;
      if (to || c != e.cyc) begin n_fail++; $display("FAIL rd_latency: rdy cycle %0d, expected %0d", c, e.cyc); end
      n_cmp++;
      if (oe !== 1'b1 || rd !== e.data) begin
         n_fail++; $display("FAIL rd_data: oe=%b rdata=%h, expected oe=1 rdata=%h", oe, rd, e.data);
      end
      @(negedge clk);
      n_cmp++;
      if (oe_v !== 1'b0 || rdata_v !== 8'hA5) begin
         n_fail++; $display("FAIL rd_hold: oe=%b rdata=%h, expected oe=0 rdata=a5", oe_v, rdata_v);
      end
   endtask

   task automatic test_stray_start();
      int c; bit to; logic oe; logic [7:0] rd; exp_t e; int r0;
      sel = 1'b0;
      get_grant();
      xfer(1'b1, 8'h55, 8'h11, c, to, oe, rd);
      e = sbq.pop_front();
      n_cmp++;
      if (to || c != e.cyc) begin n_fail++; $display("FAIL stray_pre_wr: rdy cycle %0d, expected %0d", c, e.cyc); end
      req_t = 1'b0;
      repeat (3) @(negedge clk);
      r0      = rdy_cnt;
      req_t   = 1'b1;
      start_t = 1'b1;
      addr_t  = 8'h55;
      wdata_t = 8'hEE;
      mode_t  = 2'b01;
      @(negedge clk);
      start_t = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (gnt_v !== 1'b1 || rdy_cnt != r0) begin
         n_fail++; $display("FAIL stray_start: gnt=%b rdy pulses=%0d, expected gnt=1 and 0 pulses", gnt_v, rdy_cnt - r0);
      end
      xfer(1'b0, 8'h55, 8'h00, c, to, oe, rd);
      e = sbq.pop_front();
      n_cmp++;
      if (to || c != e.cyc) begin n_fail++; $display("FAIL stray_rd_latency: rdy cycle %0d, expected %0d", c, e.cyc); end
      n_cmp++;
      if (oe !== 1'b1 || rd !== e.data) begin
         n_fail++; $display("FAIL stray_rd_data: oe=%b rdata=%h, expected oe=1 rdata=%h", oe, rd, e.data);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_write();
      int c; bit to; logic oe; logic [7:0] rd; exp_t e; logic [7:0] saved;
      sel = 1'b0;
      get_grant();
      xfer(1'b1, 8'h20, 8'h00, c, to, oe, rd);
      e = sbq.pop_front();
      n_cmp++;
      if (to || c != e.cyc) begin n_fail++; $display("FAIL rst_pre_wr: rdy cycle %0d, expected %0d", c, e.cyc); end
      @(negedge clk);
      saved = mem_m[8'h20];
      drive_start(1'b1, 8'h20, 8'h3C);
      rst = 1'b1;
      void'(sbq.pop_back());
      mem_m[8'h20] = saved;
      @(negedge clk);
      n_cmp++;
      if ({b2.gnt, b2.rdy, b2.rdata_oe, b2.rdata} !== 11'd0) begin
         n_fail++; $display("FAIL rst_mid_outputs: gnt/rdy/oe/rdata=%b, expected all 0", {b2.gnt, b2.rdy, b2.rdata_oe, b2.rdata});
      end
      rst = 1'b0;
      @(negedge clk);
      get_grant();
      xfer(1'b0, 8'h20, 8'h00, c, to, oe, rd);
      e = sbq.pop_front();
      n_cmp++;
      if (to || c != e.cyc) begin n_fail++; $display("FAIL rst_rd_latency: rdy cycle %0d, expected %0d", c, e.cyc); end
      n_cmp++;
      if (oe !== 1'b1 || rd !== 8'h00) begin
         n_fail++; $display("FAIL rst_no_commit: oe=%b rdata=%h, expected oe=1 rdata=00", oe, rd);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int c; bit to; logic oe; logic [7:0] rd; exp_t e; int prev;
      req_t = 1'b0;
      repeat (2) @(negedge clk);
      sel = 1'b1;
      get_grant();
      for (int pass = 0; pass < 2; pass++) begin
         prev = -1;
         for (int i = 0; i < 4; i++) begin
            xfer(pass == 0, 8'(i), 8'(8'hC0 + i), c, to, oe, rd);
            e = sbq.pop_front();
            n_cmp++;
            if (to || c != e.cyc) begin n_fail++; $display("FAIL b2b_latency[%0d.%0d]: rdy cycle %0d, expected %0d", pass, i, c, e.cyc); end
            if (i > 0) begin
               n_cmp++;
               if (c - prev != 2) begin n_fail++; $display("FAIL b2b_spacing[%0d.%0d]: %0d cycles, expected 2", pass, i, c - prev); end
            end
            n_cmp++;
            if (oe !== e.rd || (e.rd && rd !== e.data)) begin
               n_fail++; $display("FAIL b2b_data[%0d.%0d]: oe=%b rdata=%h, expected oe=%b rdata=%h", pass, i, oe, rd, e.rd, e.data);
            end
            prev = c;
            @(negedge clk);
         end
      end
      req_t = 1'b0;
      repeat (2) @(negedge clk);
      sel = 1'b0;
   endtask

`ifdef BUS_SLAVE_MEM_STATS_EN
   task automatic test_stats();
      int c; bit to; logic oe; logic [7:0] rd; exp_t e; logic [15:0] rd0;
      sel = 1'b0;
      get_grant();
      force u_dut2.wr_count_q = 16'hFFFE;
      @(negedge clk);
      release u_dut2.wr_count_q;
      rd0 = rd_cnt2;
      for (int i = 0; i < 3; i++) begin
         xfer(1'b1, 8'(8'h40 + i), 8'(i), c, to, oe, rd);
         e = sbq.pop_front();
         n_cmp++;
         if (to || c != e.cyc) begin n_fail++; $display("FAIL stats_wr_latency[%0d]: rdy cycle %0d, expected %0d", i, c, e.cyc); end
         @(negedge clk);
      end
      n_cmp++;
      if (wr_cnt2 !== 16'hFFFF) begin n_fail++; $display("FAIL stats_wr_sat: wr_count=%h, expected ffff", wr_cnt2); end
      n_cmp++;
      if (rd_cnt2 !== rd0) begin n_fail++; $display("FAIL stats_rd_hold: rd_count=%h, expected %h", rd_cnt2, rd0); end
   endtask
`endif

   initial begin
      test_reset();
      test_req_no_start();
      test_write_read();
      test_stray_start();
      test_reset_mid_write();
      test_back_to_back();
`ifdef BUS_SLAVE_MEM_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_slave_mem.md
BUS_SLAVE_MEM -- requirements
Module: bus_slave_mem

Interface
REQ-001 SHALL have parameter AWIDTH, default 8: address width, memory depth 2**AWIDTH words.
REQ-002 SHALL have parameter DWIDTH, default 8: data word width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0..15: extra access wait states.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req, input, 1 bit: master bus request.
REQ-007 SHALL have port gnt, output, 1 bit: bus grant to the master.
REQ-008 SHALL have port start, input, 1 bit: transfer start strobe, valid only while gnt=1.
REQ-009 SHALL have port mode, input, 2 bits: bit0 selects 0=read, 1=write; bit1 is reserved and ignored.
REQ-010 SHALL have port addr, input, AWIDTH bits: word address.
REQ-011 SHALL have port wdata, input, DWIDTH bits: write data, sampled with start.
REQ-012 SHALL have port rdata, output, DWIDTH bits: read data.
REQ-013 SHALL have port rdata_oe, output, 1 bit: rdata valid and driving the shared data lines.
REQ-014 SHALL have port rdy, output, 1 bit: one-cycle transfer-complete pulse.

Function
REQ-015 SHALL implement an FSM with states IDLE, GRANT, ACCESS and DONE.
REQ-016 IDLE: when req=1, SHALL move to GRANT with gnt=1 from the next cycle; start is ignored in IDLE, including start and req asserted in the same cycle.
REQ-017 GRANT: gnt SHALL stay 1; when req=0 and start=0, SHALL return to IDLE with gnt=0 next cycle.
REQ-018 GRANT: when start=1 is sampled, SHALL latch addr, mode[0] and wdata, load the wait counter with WAIT_CYCLES and enter ACCESS.
REQ-019 GRANT: start=1 SHALL take priority over req=0 in the same cycle.
REQ-020 ACCESS: SHALL decrement the counter each cycle; when it reaches 0, SHALL perform the access and enter DONE.
REQ-021 Read access: SHALL register rdata = mem[latched addr].
REQ-022 Write access: SHALL commit mem[latched addr] = latched wdata exactly once.
REQ-023 Latency: for start sampled at edge k, rdy SHALL be 1 during cycle k+WAIT_CYCLES+1 only; WAIT_CYCLES=0 gives rdy in the cycle after start.
REQ-024 DONE: rdy=1 and gnt=1 for exactly one cycle; rdata_oe=1 only for reads; next state SHALL be GRANT if req=1, else IDLE.
REQ-025 Back-to-back transfers: the first possible next start is the cycle after DONE.
REQ-026 Input changes on addr, wdata and mode outside the start cycle SHALL NOT affect an in-flight transfer.
REQ-027 Address wrap: all 2**AWIDTH addresses are valid; there is no out-of-range case.
REQ-028 rdata SHALL hold its last read value when rdata_oe=0.

Reset
REQ-029 rst=1 SHALL force IDLE, gnt=0, rdy=0, rdata_oe=0, rdata=0 and wait counter=0 at the next edge.
REQ-030 Reset during ACCESS SHALL abort the transfer without committing the write; memory contents are not reset.

Configuration
REQ-031 With BUS_SLAVE_MEM_STATS_EN defined, SHALL add 16-bit outputs rd_count and wr_count.
REQ-032 With BUS_SLAVE_MEM_STATS_EN defined, rd_count and wr_count SHALL increment on each completed read or write in DONE, saturate at 16'hFFFF and reset to 0.
REQ-033 Without BUS_SLAVE_MEM_STATS_EN, the counter ports and logic SHALL be absent.

Structure
REQ-034 Shared package simple_bus_pkg SHALL hold the FSM state enum, the mode bit constants (MODE_READ=0, MODE_WRITE=1) and the WAIT_CYCLES maximum (15).
REQ-035 Storage SHALL be one sub-module, bus_slave_mem_array: single-port synchronous RAM, parameterised by AWIDTH and DWIDTH, with no reset.

Verification
REQ-036 Write then read, WAIT_CYCLES=2: write 8'hA5 to addr 8'h10, then read addr 8'h10 -> rdy 3 cycles after each start; rdata=8'hA5 with rdata_oe=1 in the read's DONE cycle.
REQ-037 Request without start: req high 3 cycles then low -> gnt high the cycle after req rises, low the cycle after req falls; no rdy.
REQ-038 Stray start: start=1 in IDLE together with req -> no latch, no rdy; transfer begins only on a start issued in GRANT.
REQ-039 Reset mid-write: rst in the ACCESS cycle of a write of 8'h3C to addr 8'h20 (previous content 8'h00) -> all outputs 0 next cycle; later read of 8'h20 returns 8'h00.
REQ-040 Back-to-back with WAIT_CYCLES=0: start on the cycle after each rdy, 4 writes to addr 8'h00..8'h03 -> rdy every 2 cycles; readback matches.
REQ-041 Stats (macro on): force wr_count to 16'hFFFE, perform 3 writes -> wr_count reads 16'hFFFF and holds; rd_count unchanged.
